// File: rtl/lsu_align_unit.sv
// lsu_align_unit: load/store alignment unit between execute and a word-wide
// data bus. Issues one aligned beat, or two beats when an access crosses a
// bus-word boundary, and merges/extends the returned load data by funct3.
//
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses fault
// without touching the bus, and the second-beat path is not built.
module lsu_align_unit #(
    parameter int XLEN     = 32,
    parameter bit RESP_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_fault
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_RSP0,
        S_REQ1,
        S_RSP1,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic              split_q, split_d;
    logic [XLEN-1:0]   wdata_hi_q, wdata_hi_d;
    logic [NB-1:0]     wstrb_hi_q, wstrb_hi_d;
    logic [XLEN-1:0]   rdata0_q, rdata0_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]     mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_fault_q, resp_fault_d;

    // Request decode signals (valid only while a request is presented).
    logic [OFFW-1:0]   req_off;
    logic [3:0]        req_size;
    logic [NB-1:0]     req_mask;
    logic              req_legal;
    logic              req_bad;
    logic              req_split;
    logic [2*NB-1:0]   strb_full;
    logic [2*XLEN-1:0] wdata_full;

    // Load merge signals.
    logic [XLEN-1:0]   merge_lo, merge_hi, raw, keep, fill, load_data;
    logic              sign_bit;

    logic              last_rsp;
    logic              comb_resp;

    // Decode size/legality of the incoming request and pre-shift both beats.
    always_comb begin
        req_off  = req_addr[OFFW-1:0];
        req_size = 4'd1 << req_funct3[1:0];
        case (req_funct3[1:0])
            2'd0:    req_mask = NB'(8'h01);
            2'd1:    req_mask = NB'(8'h03);
            2'd2:    req_mask = NB'(8'h0F);
            default: req_mask = '1;
        endcase
        req_legal = (req_funct3 != 3'd7)
                 && !(req_we && req_funct3[2])
                 && ((XLEN == 64) || ((req_funct3 != 3'd3) && (req_funct3 != 3'd6)));
        // Low half feeds beat 0, high half is what spills into beat 1.
        strb_full  = {{NB{1'b0}}, req_mask} << req_off;
        wdata_full = {{XLEN{1'b0}}, req_wdata} << {req_off, 3'b000};
`ifdef LSU_MISALIGN_TRAP_EN
        req_bad   = !req_legal || ((req_off & OFFW'(req_size - 4'd1)) != '0);
        req_split = 1'b0;
`else
        req_bad   = !req_legal;
        req_split = (int'(req_off) + int'(req_size)) > NB;
`endif
    end

    // Merge the one or two read beats and sign/zero-extend by funct3.
    always_comb begin
        merge_lo = split_q ? rdata0_q : mem_rdata;
        merge_hi = split_q ? mem_rdata : '0;
        raw      = XLEN'({merge_hi, merge_lo} >> {off_q, 3'b000});
        case (funct3_q[1:0])
            2'd0: begin
                keep     = XLEN'(8'hFF);
                sign_bit = raw[7];
            end
            2'd1: begin
                keep     = XLEN'(16'hFFFF);
                sign_bit = raw[15];
            end
            2'd2: begin
                keep     = XLEN'(32'hFFFF_FFFF);
                sign_bit = raw[31];
            end
            default: begin
                keep     = '1;
                sign_bit = raw[XLEN-1];
            end
        endcase
        fill      = {XLEN{!funct3_q[2] && sign_bit}};
        load_data = (raw & keep) | (fill & ~keep);
    end

    // Next-state and datapath register updates for the beat sequencer.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can
        // leave a variable unassigned and infer a latch.
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        split_d      = split_q;
        wdata_hi_d   = wdata_hi_q;
        wstrb_hi_d   = wstrb_hi_q;
        rdata0_d     = rdata0_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d         = req_we;
                    funct3_d     = req_funct3;
                    off_d        = req_off;
                    split_d      = req_split;
                    resp_fault_d = req_bad;
                    resp_rdata_d = '0;
                    if (req_bad) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_REQ0;
                        mem_we_d    = req_we;
                        mem_addr_d  = req_addr & ~XLEN'(NB - 1);
                        mem_wdata_d = req_we ? wdata_full[XLEN-1:0] : '0;
                        mem_wstrb_d = req_we ? strb_full[NB-1:0] : '0;
                        wdata_hi_d  = req_we ? wdata_full[2*XLEN-1:XLEN] : '0;
                        wstrb_hi_d  = req_we ? strb_full[2*NB-1:NB] : '0;
                    end
                end
            end
            S_REQ0: begin
                if (mem_ready) state_d = S_RSP0;
            end
            S_RSP0: begin
                if (mem_rvalid) begin
                    rdata0_d = mem_rdata;
                    if (split_q) begin
                        state_d     = S_REQ1;
                        mem_addr_d  = mem_addr_q + XLEN'(NB);
                        mem_wdata_d = wdata_hi_q;
                        mem_wstrb_d = wstrb_hi_q;
                    end else begin
                        resp_rdata_d = we_q ? '0 : load_data;
                        resp_fault_d = 1'b0;
                        state_d      = RESP_REG ? S_DONE : S_IDLE;
                    end
                end
            end
`ifdef LSU_MISALIGN_TRAP_EN
            // Second-beat states are unreachable: nothing ever splits.
`else
            S_REQ1: begin
                if (mem_ready) state_d = S_RSP1;
            end
            S_RSP1: begin
                if (mem_rvalid) begin
                    resp_rdata_d = we_q ? '0 : load_data;
                    resp_fault_d = 1'b0;
                    state_d      = RESP_REG ? S_DONE : S_IDLE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            off_q        <= '0;
            split_q      <= 1'b0;
            wdata_hi_q   <= '0;
            wstrb_hi_q   <= '0;
            rdata0_q     <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            split_q      <= split_d;
            wdata_hi_q   <= wdata_hi_d;
            wstrb_hi_q   <= wstrb_hi_d;
            rdata0_q     <= rdata0_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    // With an unregistered response the final RSP beat completes directly.
    assign last_rsp  = ((state_q == S_RSP0) && !split_q) || (state_q == S_RSP1);
    assign comb_resp = !RESP_REG && last_rsp && mem_rvalid;

    assign req_ready  = (state_q == S_IDLE);
    assign mem_valid  = (state_q == S_REQ0) || (state_q == S_REQ1);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign resp_valid = (state_q == S_DONE) || comb_resp;
    assign resp_rdata = comb_resp ? (we_q ? '0 : load_data) : resp_rdata_q;
    assign resp_fault = comb_resp ? 1'b0 : resp_fault_q;

endmodule

// File: tb/tb_lsu_align_unit.sv
// Scoreboard bench for lsu_align_unit (XLEN=32, registered response).
// A byte-lane reference model predicts bus beats and responses per request;
// a bus responder checks beats and a monitor checks responses.
module tb_lsu_align_unit;

    localparam int XLEN = 32;
    localparam int NB   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid, req_ready, req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr, req_wdata;
    logic            mem_valid, mem_ready, mem_we;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic [NB-1:0]   mem_wstrb;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            resp_valid, resp_fault;
    logic [XLEN-1:0] resp_rdata;

    always #5 clk = ~clk;

    lsu_align_unit #(.XLEN(XLEN), .RESP_REG(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        we;
        logic [31:0] rdata;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
    } resp_t;

    beat_t exp_beats[$];
    resp_t exp_resp[$];

    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int accept_cyc = 0;
    int stall_left = 0;
    int rsp_wait   = 0;
    int beats_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: walks the accessed bytes lane by lane.
    function automatic void model_push(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [31:0] rd0, input logic [31:0] rd1,
                                       input int stall, input int rwait);
        int          size;
        int          off;
        int          lane;
        bit          legal, mis, split, bad;
        logic [63:0] w64;
        logic [3:0]  s0, s1;
        logic [31:0] res;
        beat_t       b;
        resp_t       r;
        size  = 1 << f3[1:0];
        off   = int'(addr[1:0]);
        legal = (f3 != 3'd7) && !(we && f3[2]) && (f3 != 3'd3) && (f3 != 3'd6);
        mis   = (off % size) != 0;
        split = (off + size) > NB;
`ifdef LSU_MISALIGN_TRAP_EN
        bad = !legal || mis;
`else
        bad = !legal;
`endif
        if (bad) begin
            r.rdata = '0;
            r.fault = 1'b1;
            r.lat   = 1;
            exp_resp.push_back(r);
            return;
        end
        w64 = {32'b0, wdata} << (8 * off);
        s0  = '0;
        s1  = '0;
        res = '0;
        for (int i = 0; i < size; i++) begin
            lane = off + i;
            if (lane < NB) begin
                s0[lane]     = 1'b1;
                res[8*i +: 8] = rd0[8*lane +: 8];
            end else begin
                s1[lane-NB]  = 1'b1;
                res[8*i +: 8] = rd1[8*(lane-NB) +: 8];
            end
        end
        if (!f3[2] && res[8*size-1])
            for (int k = 8 * size; k < 32; k++) res[k] = 1'b1;
        b.addr  = addr & 32'hFFFF_FFFC;
        b.we    = we;
        b.wdata = w64[31:0];
        b.strb  = we ? s0 : 4'b0;
        b.rdata = rd0;
        exp_beats.push_back(b);
        if (split) begin
            b.addr  = b.addr + 32'd4;
            b.wdata = w64[63:32];
            b.strb  = we ? s1 : 4'b0;
            b.rdata = rd1;
            exp_beats.push_back(b);
        end
        r.rdata = we ? 32'b0 : res;
        r.fault = 1'b0;
        r.lat   = split ? (5 + stall + 2 * rwait) : (3 + stall + rwait);
        exp_resp.push_back(r);
    endfunction

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input int stall, input int rwait);
        int n;
        @(negedge clk);
        stall_left = stall;
        rsp_wait   = rwait;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("accept_timeout", 0, 1);
        accept_cyc = cyc;
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_resp.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_resp.size() != 0) begin
            check("resp_timeout", exp_resp.size(), 0);
            exp_resp.delete();
            exp_beats.delete();
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd0,
                          input logic [31:0] rd1, input int stall, input int rwait);
        model_push(we, f3, addr, wdata, rd0, rd1, stall, rwait);
        drive_req(we, f3, addr, wdata, stall, rwait);
        wait_idle();
    endtask

    // Bus responder: checks each beat, optional stall and read-data wait.
    initial begin
        bit          pending = 1'b0;
        int          pwait   = 0;
        logic [31:0] prdata  = '0;
        beat_t       b;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending    = 1'b0;
                mem_ready  = 1'b0;
                mem_rvalid = 1'b0;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
                if (pending) begin
                    if (pwait > 0) pwait--;
                    else begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = prdata;
                        pending    = 1'b0;
                    end
                end else if (!mem_valid) begin
                    mem_rvalid = 1'($urandom_range(0, 1));  // stray, must be ignored
                end
                if (mem_valid) begin
                    if (exp_beats.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                        mem_ready = 1'b1;
                    end else if (stall_left > 0) begin
                        check("stall_addr", mem_addr, exp_beats[0].addr);
                        check("stall_strb", mem_wstrb, exp_beats[0].strb);
                        if (exp_beats[0].we) check("stall_wdata", mem_wdata, exp_beats[0].wdata);
                        stall_left--;
                        mem_ready = 1'b0;
                    end else begin
                        b = exp_beats.pop_front();
                        check("beat_addr", mem_addr, b.addr);
                        check("beat_strb", mem_wstrb, b.strb);
                        check("beat_we", mem_we, b.we);
                        if (b.we) check("beat_wdata", mem_wdata, b.wdata);
                        mem_ready = 1'b1;
                        pending   = 1'b1;
                        pwait     = rsp_wait;
                        prdata    = b.rdata;
                        beats_seen++;
                    end
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));  // no effect while idle
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every completion pulse.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid) begin
                if (exp_resp.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    r = exp_resp.pop_front();
                    check("resp_rdata", resp_rdata, r.rdata);
                    check("resp_fault", resp_fault, r.fault);
                    check("resp_latency", cyc - accept_cyc, r.lat);
                    check("ready_in_done", req_ready, 0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        logic        we;
        int          base;
        int          target;
        int          n;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        rst        = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_ctrl", {req_ready, mem_valid, mem_we, resp_valid, resp_fault}, 5'b10000);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata_strb", {mem_wdata, mem_wstrb}, 0);
        check("rst_rdata", resp_rdata, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed cases from the access table.
        do_req(1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'h8000_00F0, 32'h0, 0, 0);  // LW
        do_req(1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 32'h0, 0, 0);  // LB
        do_req(1'b0, 3'd4, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 32'h0, 0, 0);  // LBU
        do_req(1'b1, 3'd1, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 32'h0, 0, 0);  // SH
        do_req(1'b0, 3'd2, 32'h0000_00FE, 32'h0, 32'h1122_3344, 32'h5566_7788, 0, 0);
        do_req(1'b1, 3'd2, 32'h0000_0103, 32'hAABB_CCDD, 32'h0, 32'h0, 0, 1);  // split SW
        do_req(1'b0, 3'd5, 32'hFFFF_FFFE, 32'h0, 32'h8001_0000, 32'h0, 0, 0);  // LHU top
        do_req(1'b0, 3'd2, 32'hFFFF_FFFD, 32'h0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0);
        do_req(1'b1, 3'd4, 32'h0000_0100, 32'h1, 32'h0, 32'h0, 0, 0);  // illegal store
        do_req(1'b0, 3'd7, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 0, 0);  // illegal load
        do_req(1'b0, 3'd3, 32'h0000_0108, 32'h0, 32'h0, 32'h0, 0, 0);  // LD on RV32
        do_req(1'b0, 3'd6, 32'h0000_0108, 32'h0, 32'h0, 32'h0, 0, 0);  // LWU on RV32
        do_req(1'b1, 3'd2, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 32'h0, 4, 0);  // stalled SW
        do_req(1'b0, 3'd1, 32'h0000_0202, 32'h0, 32'h0000_8F00, 32'h0, 2, 3);  // slow LH

        // Randomised mix.
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            if (we) f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            else    f3 = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
            do_req(we, f3, a, $urandom, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Reset while waiting for read data of the last beat.
`ifdef LSU_MISALIGN_TRAP_EN
        a      = 32'h0000_0100;
        target = 1;
`else
        a      = 32'h0000_00FE;
        target = 2;
`endif
        base = beats_seen;
        model_push(1'b0, 3'd2, a, 32'h0, 32'h1111_1111, 32'h2222_2222, 0, 8);
        drive_req(1'b0, 3'd2, a, 32'h0, 0, 8);
        n = 0;
        while (beats_seen < base + target && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_rsp", beats_seen - base, target);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_ctrl", {req_ready, mem_valid, mem_we, resp_valid, resp_fault}, 5'b10000);
        check("rst_mid_addr", mem_addr, 0);
        check("rst_mid_wdata_strb", {mem_wdata, mem_wstrb}, 0);
        check("rst_mid_rdata", resp_rdata, 0);
        exp_beats.delete();
        exp_resp.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // Unit recovers after the abandoned transaction.
        do_req(1'b0, 3'd2, 32'h0000_0300, 32'h0, 32'h0123_4567, 32'h0, 0, 0);

        check("beats_left", exp_beats.size(), 0);
        check("resp_left", exp_resp.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_align_unit.md
Name: lsu_align_unit

Overview:
- Load/store data-path unit between the execute stage and a word-wide data-memory bus.
- Accepts one RISC-V load/store request and issues one or two aligned bus beats with byte strobes.
- Splits misaligned accesses that cross a bus-word boundary into two beats.
- Merges and sign/zero-extends load data by funct3; parametrised in XLEN with optional RV64 widths.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64. Bus word = NB = XLEN/8 bytes.
- RESP_REG, 1, 1 = registered response (DONE state); 0 = response driven combinationally in the last RSP state.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (access size and signedness)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, LSB-aligned
- mem_valid  out  1  bus request valid
- mem_ready  in  1  bus accepts request
- mem_we  out  1  bus write
- mem_addr  out  XLEN  word-aligned address (low log2(NB) bits zero)
- mem_wdata  out  XLEN  lane-shifted store data
- mem_wstrb  out  NB  byte-lane strobes (zero for loads)
- mem_rvalid  in  1  read data valid / write acknowledge
- mem_rdata  in  XLEN  bus read data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data (zero for stores)
- resp_fault  out  1  illegal funct3 or (feature) misaligned trap

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; mem_valid=0; mem_we=0; mem_addr=0; mem_wdata=0; mem_wstrb=0; resp_valid=0; resp_rdata=0; resp_fault=0. Assertion mid-transaction abandons it; no response is produced.
- Sizes: funct3 0/4 = 1 byte, 1/5 = 2 bytes, 2/6 = 4 bytes, 3 = 8 bytes. Signed: 0, 1, 2, 3. Unsigned: 4, 5, 6.
- Legality: funct3 3 and 6 are legal only when XLEN=64. funct3 7 is never legal. Stores accept funct3 0..3 only.
- Illegal request: no bus beat; DONE next cycle with resp_fault=1, resp_rdata=0.
- Offset: off = addr mod NB. split = (off + size > NB).
- FSM: IDLE -> REQ0 -> RSP0 -> [REQ1 -> RSP1 if split] -> DONE -> IDLE.
- Handshake:
  - Request accepted when req_valid && req_ready (IDLE only); all fields are latched.
  - In REQ0/REQ1, mem_valid stays high with stable addr/data/strobe until mem_ready; the next cycle moves to RSP.
  - RSP waits any number of cycles for mem_rvalid.
  - DONE drives resp_valid for exactly one cycle.
  - A new request is accepted in the cycle after DONE.
- Minimum latency with zero-wait bus (accept to resp_valid): 3 cycles aligned, 5 cycles split.
- Beat 0: mem_addr = addr & ~(NB-1); wdata = req_wdata << 8*off; wstrb = ((1<<size)-1) << off, truncated to NB bits.
- Beat 1: mem_addr = beat0 addr + NB, wrapping modulo 2^XLEN; wdata = req_wdata >> 8*(NB-off); wstrb = ((1<<size)-1) >> (NB-off).
- Load merge:
  - raw = (rdata0 >> 8*off) | (rdata1 << 8*(NB-off)), the second term only when split.
  - Keep the low size bytes; sign-extend or zero-extend to XLEN by funct3.
- Beat 0 rdata is captured on mem_rvalid in RSP0. mem_rvalid outside the RSP states is ignored.
- Store response: resp_rdata=0, resp_fault=0.
- mem_ready asserted while mem_valid is low has no effect.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: any access with off mod size != 0 takes no bus beat; DONE next cycle with resp_fault=1. The REQ1/RSP1 path is not built.
- Undefined: misaligned accesses are split as above; resp_fault only flags illegal funct3.

Test Plan:
- XLEN=32, LW addr 0x100, rdata 0x8000_00F0, zero-wait bus -> one beat at 0x100, wstrb 0, resp_rdata 0x8000_00F0, resp_valid 3 cycles after accept.
- LB addr 0x103, rdata 0x80AA_BBCC -> resp_rdata 0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- SH addr 0x102, wdata 0x1234_ABCD -> mem_wdata 0xABCD_0000, wstrb 4'b1100, single beat, resp_rdata 0.
- LW addr 0x0FE, beat0 rdata 0x1122_3344, beat1 rdata 0x5566_7788:
  - Without macro -> beats at 0x0FC then 0x100; resp_rdata 0x7788_1122; latency 5.
  - With LSU_MISALIGN_TRAP_EN -> no mem_valid; resp_fault=1.
- Store funct3=4 or load funct3=7 (XLEN=32) -> no mem_valid; resp_fault=1 one cycle after accept. XLEN=64 LD at 0x8 -> one beat, full 64-bit data.
- mem_ready held low 4 cycles in REQ0 -> mem_addr/wdata/wstrb stable. Assert rst during RSP1 -> all outputs at reset values immediately; req_ready=1; no resp_valid.
